npc_pc_unit: RTL and testbench

//  Fetch-side consumer of the branch/jump decision produced in D. Holds the F-stage PC register,

---
 rtl/npc_pc_unit.sv | 82 ++++++++
 tb/tb_npc_pc_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/npc_pc_unit.sv
// Fetch-stage PC register and next-PC selection (branch/jump/jr, eret, exception entry, stall).
// Optional fetch address-error check is built when NPC_ADEL_CHECK_EN is defined.
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret_D,
    input  logic [31:0] EPC,
    input  logic [2:0]  NPC_OP,
    input  logic        br_D,
    input  logic [31:0] PC_D,
    input  logic [25:0] imm26_D,
    input  logic [31:0] ra_D,
    output logic [31:0] PC_F,
    output logic        BD_F,
    output logic        flush_F,
    output logic        AdEL_F
);

    typedef enum logic [0:0] {StRun, StExc} mode_e;

    mode_e       mode_q, mode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] seq_tgt, br_tgt, j_tgt;

    // Reset value is presented during the reset cycle itself, not only after the edge.
    assign PC_F    = reset ? RESET_PC : pc_q;
    assign seq_tgt = PC_F + 32'd4;
    assign br_tgt  = PC_D + 32'd4 + {{14{imm26_D[15]}}, imm26_D[15:0], 2'b00};
    assign j_tgt   = {PC_D[31:28], imm26_D, 2'b00};

    assign BD_F    = br_D & ~reset & (mode_q == StRun);
    assign flush_F = eret_D & ~stall & ~req & ~reset;

    always_comb begin
        pc_d   = pc_q;
        mode_d = StRun;
        if (req) begin
            pc_d   = EXC_PC;
            mode_d = StExc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (eret_D) begin
            pc_d = EPC;
        end else begin
            case (NPC_OP)
                3'b001:  pc_d = br_tgt;
                3'b010:  pc_d = j_tgt;
                3'b011:  pc_d = ra_D;
                default: pc_d = seq_tgt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            mode_q <= StRun;
        end else begin
            pc_q   <= pc_d;
            mode_q <= mode_d;
        end
    end

`ifdef NPC_ADEL_CHECK_EN
    logic adel_raw;
    assign adel_raw = (pc_q[1:0] != 2'b00) | (pc_q < IM_LO) | (pc_q > IM_HI);
    // The handler's first fetch (registered EXC mode) never raises an address error.
    assign AdEL_F   = adel_raw & ~reset & (mode_q == StRun);
`else
    logic unused_im_bounds;
    assign unused_im_bounds = ^{IM_LO, IM_HI};
    assign AdEL_F           = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: vector table of per-cycle stimulus with a next-PC scoreboard,
// followed by hand-written fetch address-error and mid-branch reset sequences.
module tb_npc_pc_unit;

`ifdef NPC_ADEL_CHECK_EN
    localparam bit AdelEn = 1'b1;
`else
    localparam bit AdelEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, req, eret_D, br_D;
    logic [31:0] EPC, PC_D, ra_D;
    logic [2:0]  NPC_OP;
    logic [25:0] imm26_D;
    logic [31:0] PC_F;
    logic        BD_F, flush_F, AdEL_F;

    always #5 clk = ~clk;

    npc_pc_unit dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .req     (req),
        .eret_D  (eret_D),
        .EPC     (EPC),
        .NPC_OP  (NPC_OP),
        .br_D    (br_D),
        .PC_D    (PC_D),
        .imm26_D (imm26_D),
        .ra_D    (ra_D),
        .PC_F    (PC_F),
        .BD_F    (BD_F),
        .flush_F (flush_F),
        .AdEL_F  (AdEL_F)
    );

    typedef struct {
        logic        rst, stl, rq, er, br;
        logic [2:0]  op;
        logic [31:0] epc, pcd, ra;
        logic [25:0] imm;
        logic        bd, fl;
        logic [31:0] nxt;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    logic [31:0] model_pc;
    logic        model_exc;
    int          n_cmp;
    int          n_fail;

    function automatic vec_t mk(input logic rst, input logic stl, input logic rq, input logic er,
                                input logic br, input logic [2:0] op, input logic [31:0] epc,
                                input logic [31:0] pcd, input logic [31:0] ra,
                                input logic [25:0] imm, input logic bd, input logic fl,
                                input logic [31:0] nxt, input string name);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rq = rq; v.er = er; v.br = br; v.op = op;
        v.epc = epc; v.pcd = pcd; v.ra = ra; v.imm = imm;
        v.bd = bd; v.fl = fl; v.nxt = nxt; v.name = name;
        return v;
    endfunction

    function automatic logic bad_addr(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [31:0] exp_pc;
        reset = v.rst; stall = v.stl; req = v.rq; eret_D = v.er; br_D = v.br;
        NPC_OP = v.op; EPC = v.epc; PC_D = v.pcd; ra_D = v.ra; imm26_D = v.imm;
        #1;
        chk({v.name, ".pc_now"}, PC_F, v.rst ? 32'h0000_3000 : model_pc);
        chk({v.name, ".bd"}, {31'd0, BD_F}, {31'd0, v.bd});
        chk({v.name, ".flush"}, {31'd0, flush_F}, {31'd0, v.fl});
        chk({v.name, ".adel"}, {31'd0, AdEL_F},
            {31'd0, AdelEn && !v.rst && !model_exc && bad_addr(model_pc)});
        sb_q.push_back(v.nxt);
        @(posedge clk);
        #1;
        exp_pc = sb_q.pop_front();
        chk({v.name, ".pc_next"}, PC_F, exp_pc);
        model_pc  = v.nxt;
        model_exc = v.rq & ~v.rst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_fail = 0; model_pc = 32'h0; model_exc = 1'b0;
        //              rst stl rq er br op    epc            pcd            ra             imm           bd fl nxt
        tbl.push_back(mk(1, 0, 0, 1, 1, 3'b001, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3000, "rst0"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3000, "rst1"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3004, "seq0"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3008, "seq1"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b001, 32'h0, 32'h3008, 32'h0, 26'h000FFFE, 1, 0,
                         32'h3004, "br_back"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b001, 32'h0, 32'hFFFF_FFFC, 32'h0, 26'h0000001, 1, 0,
                         32'h0000_0004, "br_wrap"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b010, 32'h0, 32'h3010, 32'h0, 26'h0000C10, 1, 0,
                         32'h3040, "j"));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3100, 26'h0, 1, 0, 32'h3040, "jr_st0"));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3100, 26'h0, 1, 0, 32'h3040, "jr_st1"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3100, 26'h0, 1, 0, 32'h3100, "jr_go"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3104, "seq2"));
        tbl.push_back(mk(0, 1, 1, 1, 0, 3'b000, 32'h3020, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4180,
                         "req_st"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4184, "exc_bd"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 1, 0, 32'h4188, "run_bd"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4180, "req_a"));
        tbl.push_back(mk(0, 0, 1, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4180, "req_b"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4184, "exc_seq"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 32'h3020, 32'h0, 32'h0, 26'h0, 0, 1, 32'h3020, "eret"));
        tbl.push_back(mk(0, 1, 0, 1, 0, 3'b000, 32'h3024, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3020,
                         "eret_st"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 32'h3024, 32'h0, 32'h0, 26'h0, 0, 1, 32'h3024,
                         "eret2"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b111, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3028, "op7"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 26'h0, 1, 0, 32'h302C, "op4"));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3002, 26'h0, 0, 0, 32'h3000,
                         "rst_mid"));

        foreach (tbl[i]) apply(tbl[i]);

        // Fetch address error sequence: misaligned and out-of-range jr targets, then EXC entry.
        apply(mk(0, 0, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3002, 26'h0, 1, 0, 32'h3002, "jr_mis"));
        chk("adel_mis", {31'd0, AdEL_F}, {31'd0, AdelEn});
        apply(mk(0, 0, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h7000, 26'h0, 1, 0, 32'h7000, "jr_hi"));
        chk("adel_hi", {31'd0, AdEL_F}, {31'd0, AdelEn});
        apply(mk(0, 0, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h4180, "adel_req"));
        chk("adel_exc", {31'd0, AdEL_F}, 32'd0);
        apply(mk(0, 0, 0, 0, 1, 3'b011, 32'h0, 32'h0, 32'h3002, 26'h0, 0, 0, 32'h3002, "jr_mis2"));
        chk("adel_mis2", {31'd0, AdEL_F}, {31'd0, AdelEn});

        // Reset asserted while a branch is in D.
        apply(mk(1, 0, 0, 0, 1, 3'b001, 32'h0, 32'h3008, 32'h0, 26'h0000010, 0, 0, 32'h3000,
                 "rst_br"));
        chk("adel_after_rst", {31'd0, AdEL_F}, 32'd0);
        apply(mk(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 0, 0, 32'h3004, "post_rst"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
